// File: rtl/demux_pkg.sv
// Shared sizing for the 1-to-4 stream demux and its per-destination FIFOs.
// Pure constants: no logic, no latency, no backpressure of its own.
// Consumers import this package to keep selector and FIFO widths consistent.
package demux_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int N_OUT      = 4;
    localparam int DEPTH_DEF  = 2;
    localparam int SEL_W      = $clog2(N_OUT);

endpackage

// File: rtl/stream_fifo2.sv
// Small synchronous FIFO with a registered head output that holds its last value when drained.
// Latency: a push into an empty FIFO is visible on head/!empty one cycle later.
// Backpressure: push is ignored while full (even if popping that cycle); pop is ignored while empty.
module stream_fifo2
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] mem_nxt [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [DATA_W-1:0] head_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = head_q;

    always_comb begin
        mem_nxt    = mem;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_push) begin
            mem_nxt[wr_ptr] = din;
            wr_ptr_nxt      = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // head is refreshed from the post-update state so it stays put when the FIFO drains
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= mem_nxt[k];
            end
            if (count_nxt != '0) begin
                head_q <= mem_nxt[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/demux_1to4_stream.sv
// Routes one upstream valid/ready stream to one of four buffered destinations chosen by s_sel.
// Latency: one cycle from acceptance to m_valid/m_data when the destination FIFO was empty.
// Backpressure: s_ready follows fullness of the FIFO addressed by s_sel; other destinations do not block.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [SEL_W-1:0]  s_sel,
    input  logic [DATA_W-1:0] s_data,
    output logic [N_OUT-1:0]  m_valid,
    input  logic [N_OUT-1:0]  m_ready,
    output logic [DATA_W-1:0] m_data0,
    output logic [DATA_W-1:0] m_data1,
    output logic [DATA_W-1:0] m_data2,
    output logic [DATA_W-1:0] m_data3,
    output logic              busy
);

    logic [N_OUT-1:0]  fifo_full;
    logic [N_OUT-1:0]  fifo_empty;
    logic [N_OUT-1:0]  fifo_push;
    logic [N_OUT-1:0]  fifo_pop;
    logic [DATA_W-1:0] fifo_head [N_OUT];

    assign s_ready = !fifo_full[s_sel];

    always_comb begin
        fifo_push = '0;
        if (s_valid && !fifo_full[s_sel]) begin
            fifo_push[s_sel] = 1'b1;
        end
    end

    assign m_valid  = ~fifo_empty;
    assign fifo_pop = m_valid & m_ready;
    assign busy     = |m_valid;

    for (genvar i = 0; i < N_OUT; i++) begin : g_dest
        stream_fifo2 #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[i]),
            .din   (s_data),
            .pop   (fifo_pop[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .head  (fifo_head[i])
        );
    end

    assign m_data0 = fifo_head[0];
    assign m_data1 = fifo_head[1];
    assign m_data2 = fifo_head[2];
    assign m_data3 = fifo_head[3];

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench: directed scenarios then random traffic, checked against per-destination queues.
module tb_demux_1to4_stream;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [1:0]        s_sel = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic [3:0]        m_valid;
    logic [3:0]        m_ready = '0;
    logic [DATA_W-1:0] m_data0, m_data1, m_data2, m_data3;
    logic              busy;

    demux_1to4_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sel   (s_sel),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data0 (m_data0),
        .m_data1 (m_data1),
        .m_data2 (m_data2),
        .m_data3 (m_data3),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference: each destination is just an ordered list of beats still owed downstream.
    logic [DATA_W-1:0] exp_q [4][$];
    logic [DATA_W-1:0] last_val [4];
    int                occ_pre [4];
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual == required) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    endtask

    function automatic logic [DATA_W-1:0] dout(input int i);
        case (i)
            0:       return m_data0;
            1:       return m_data1;
            2:       return m_data2;
            default: return m_data3;
        endcase
    endfunction

    // Monitor: compares DUT outputs with the model and retires beats on downstream handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                exp_q[i].delete();
                last_val[i] = '0;
                occ_pre[i]  = 0;
            end
        end else begin
            int any_q;
            any_q = 0;
            for (int i = 0; i < 4; i++) begin
                occ_pre[i] = exp_q[i].size();
                if (occ_pre[i] != 0) any_q = 1;
            end
            check("s_ready", int'(s_ready), int'(occ_pre[s_sel] < DEPTH));
            check("busy", int'(busy), any_q);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("m_valid[%0d]", i), int'(m_valid[i]), int'(occ_pre[i] != 0));
                if (occ_pre[i] != 0) begin
                    check($sformatf("m_data%0d", i), int'(dout(i)), int'(exp_q[i][0]));
                    if (m_ready[i]) begin
                        last_val[i] = exp_q[i].pop_front();
                    end
                end else begin
                    check($sformatf("m_data%0d_hold", i), int'(dout(i)), int'(last_val[i]));
                end
            end
        end
    end

    // Stimulus: drive one cycle, then record the beat as expected if the model says it is accepted.
    task automatic drive(input logic v, input logic [1:0] sel, input logic [DATA_W-1:0] d,
                         input logic [3:0] rdy);
        @(posedge clk); #1;
        s_valid = v;
        s_sel   = sel;
        s_data  = d;
        m_ready = rdy;
        @(negedge clk); #1;
        if (rst_n && v && occ_pre[sel] < DEPTH) exp_q[sel].push_back(d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // reset state, checked explicitly as well as by the monitor
        @(negedge clk); #2;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_data", int'({m_data0, m_data1, m_data2, m_data3}), 0);

        // single beat to destination 2
        drive(1'b1, 2'd2, 4'hA, 4'b1111);
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        drive(1'b0, 2'd0, 4'h0, 4'b1111);

        // fill destination 1, third beat blocked until a pop frees space
        drive(1'b1, 2'd1, 4'h1, 4'b0000);
        drive(1'b1, 2'd1, 4'h2, 4'b0000);
        drive(1'b1, 2'd1, 4'h3, 4'b0000);
        drive(1'b1, 2'd1, 4'h3, 4'b0010);
        drive(1'b1, 2'd1, 4'h3, 4'b0010);
        drive(1'b0, 2'd1, 4'h0, 4'b0010);
        drive(1'b0, 2'd1, 4'h0, 4'b0010);

        // interleave across destinations 0 and 3
        drive(1'b1, 2'd0, 4'h5, 4'b1111);
        drive(1'b1, 2'd3, 4'h6, 4'b1111);
        drive(1'b1, 2'd0, 4'h7, 4'b1111);
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        drive(1'b0, 2'd0, 4'h0, 4'b1111);

        // simultaneous push and pop on destination 0
        drive(1'b1, 2'd0, 4'hB, 4'b0000);
        drive(1'b1, 2'd0, 4'hC, 4'b0001);
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        drive(1'b0, 2'd0, 4'h0, 4'b0001);

        // selector-blocked: destination 3 full, switch to 0
        drive(1'b1, 2'd3, 4'h8, 4'b0000);
        drive(1'b1, 2'd3, 4'h9, 4'b0000);
        drive(1'b1, 2'd3, 4'hD, 4'b0000);
        drive(1'b1, 2'd0, 4'hD, 4'b0000);

        // reset with two full FIFOs; stored beats must never surface
        drive(1'b1, 2'd2, 4'hE, 4'b0000);
        drive(1'b1, 2'd2, 4'hF, 4'b0000);
        do_reset();
        @(negedge clk); #2;
        check("mid_rst_m_valid", int'(m_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_s_ready", int'(s_ready), 1);
        check("mid_rst_m_data", int'({m_data0, m_data1, m_data2, m_data3}), 0);

        // random traffic with mixed downstream readiness
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  DATA_W'($urandom), 4'($urandom));
            if (c == 1500) do_reset();
        end

        // drain and confirm nothing is left owed
        for (int c = 0; c < 6; c++) drive(1'b0, 2'd0, 4'h0, 4'b1111);
        for (int i = 0; i < 4; i++) check($sformatf("drained%0d", i), exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
